clk_ratio_detector: RTL and testbench

- Measures the period of a slow, divided-down clock (e.g. /2, /4, /8, /16 divider outputs) in cycles of the fast system clock.
- Reports the measured period, the recognised divide ratio, lock status and loss-of-activity.
- Sits on the consumer side of the clock-divider tree as a self-check and monitor block; fully synchronous to clk.

---
 rtl/clk_ratio_detector_if.sv | 23 ++
 rtl/clk_ratio_detector.sv | 132 +++++++++++++
 tb/tb_clk_ratio_detector.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/clk_ratio_detector_if.sv
// Handshake bundle between the divided-clock source side and the
// ratio detector: enable/sig_in in, measurement results out.
interface clk_ratio_detector_if #(
  parameter int CNT_W = 8
);
  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [2:0]       ratio_code;
  logic             locked;
  logic             timeout;

  modport master (
    output enable, sig_in,
    input  period, period_valid, ratio_code, locked, timeout
  );

  modport slave (
    input  enable, sig_in,
    output period, period_valid, ratio_code, locked, timeout
  );
endinterface

// File: rtl/clk_ratio_detector.sv
// Measures the period of a divided clock in system-clock cycles and
// reports divide ratio, lock and loss-of-activity.
module clk_ratio_detector #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  clk_ratio_detector_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE, WAIT_FIRST, MEASURE, LOCKED
  } state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LCK = 4'(LOCK_CNT);

  state_t           state, state_nxt;
  logic             s1, s2, hist, rise;
  logic [CNT_W-1:0] cnt, period_q, meas;
  logic [CNT_W:0]   cnt_inc;
  logic [3:0]       match, run_nxt;
  logic             pv_q, tmo_q, tmo_hit, same;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      hist <= 1'b0;
    end else begin
      s1   <= bus.sig_in;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign rise    = s2 & ~hist;
  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  assign meas    = (cnt_inc > {1'b0, TMO}) ? TMO
                                           : cnt_inc[CNT_W-1:0];
  assign tmo_hit = (cnt == TMO);
  // match holds the length of the current run of equal periods
  assign same    = (match != 4'd0) && (meas == period_q);

  always_comb begin
    run_nxt = 4'd1;
    if (same)
      run_nxt = (match >= LCK) ? LCK : match + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!bus.enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:       state_nxt = WAIT_FIRST;
        WAIT_FIRST: if (rise) state_nxt = MEASURE;
        MEASURE, LOCKED: begin
          if (rise)
            state_nxt = (run_nxt == LCK) ? LOCKED : MEASURE;
          else if (tmo_hit)
            state_nxt = WAIT_FIRST;
        end
        default:    state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.enable) begin
      cnt      <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      match    <= 4'd0;
      tmo_q    <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      unique case (state)
        IDLE: ;
        WAIT_FIRST: begin
          if (rise) begin
            cnt   <= '0;
            match <= 4'd0;
            tmo_q <= 1'b0;
          end
        end
        MEASURE, LOCKED: begin
          if (rise) begin
            period_q <= meas;
            pv_q     <= 1'b1;
            cnt      <= '0;
            match    <= run_nxt;
            tmo_q    <= 1'b0;
          end else if (tmo_hit) begin
            cnt   <= '0;
            match <= 4'd0;
            tmo_q <= 1'b1;
          end else begin
            cnt <= cnt_inc[CNT_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.period       = period_q;
    bus.period_valid = pv_q;
    bus.timeout      = tmo_q;
    bus.locked       = (state == LOCKED);
    bus.ratio_code   = 3'd0;
    if (state == LOCKED) begin
      unique case (1'b1)
        (period_q == CNT_W'(2)):  bus.ratio_code = 3'd1;
        (period_q == CNT_W'(4)):  bus.ratio_code = 3'd2;
        (period_q == CNT_W'(8)):  bus.ratio_code = 3'd3;
        (period_q == CNT_W'(16)): bus.ratio_code = 3'd4;
        default:                  bus.ratio_code = 3'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_ratio_detector.sv
// Random divided-clock stimulus against an event-level reference model
// built from edge timestamps and the list of measured periods.
module tb_clk_ratio_detector;

  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clk_ratio_detector_if #(.CNT_W(CNT_W)) bus ();

  clk_ratio_detector #(
    .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference state
  int  now = 0;
  int  mode = 0;
  int  last_edge = 0;
  int  plist[$];
  bit  m_s1, m_s2, m_h;
  int  e_period, e_ratio;
  bit  e_pv, e_locked, e_tmo;
  bit  cur_sig = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: got %0d expected %0d at cycle %0d",
                 tag, got, exp, now);
    end
  endtask

  function automatic int dec(input int p);
    case (p)
      2:  return 1;
      4:  return 2;
      8:  return 3;
      16: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit run_locked();
    int n = plist.size();
    if (n < LOCK_CNT) return 1'b0;
    for (int i = n - LOCK_CNT; i < n; i++)
      if (plist[i] != plist[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model(input bit r, input bit e, input bit s);
    bit ed;
    int k, p;
    ed = m_s2 && !m_h;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_h = 0;
    end else begin
      m_h = m_s2; m_s2 = m_s1; m_s1 = s;
    end
    if (r || !e) begin
      mode = 0;
      e_period = 0; e_pv = 0; e_locked = 0;
      e_ratio = 0; e_tmo = 0;
      plist.delete();
    end else begin
      e_pv = 0;
      if (mode == 0) begin
        mode = 1;
      end else if (mode == 1) begin
        if (ed) begin
          mode = 2; last_edge = now; e_tmo = 0;
          plist.delete();
        end
      end else begin
        if (ed) begin
          k = now - last_edge;
          p = (k > TIMEOUT) ? TIMEOUT : k;
          plist.push_back(p);
          last_edge = now;
          e_period = p; e_pv = 1; e_tmo = 0;
          e_locked = run_locked();
          e_ratio = e_locked ? dec(p) : 0;
        end else if (now - last_edge == TIMEOUT + 1) begin
          e_tmo = 1; e_locked = 0; e_ratio = 0;
          mode = 1;
          plist.delete();
        end
      end
    end
    now++;
  endtask

  task automatic step(input bit r, input bit e, input bit s);
    rst = r;
    bus.enable = e;
    bus.sig_in = s;
    cur_sig = s;
    @(posedge clk);
    model(r, e, s);
    @(negedge clk);
    chk("period",       bus.period,       e_period);
    chk("period_valid", bus.period_valid, e_pv);
    chk("locked",       bus.locked,       e_locked);
    chk("ratio_code",   bus.ratio_code,   e_ratio);
    chk("timeout",      bus.timeout,      e_tmo);
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) step(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < lo; i++) step(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic hold_low(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  int divs[8] = '{2, 4, 8, 16, 6, 3, 5, 9};

  initial begin
    int sel, d, hi, n;
    bus.enable = 1'b0;
    bus.sig_in = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);

    wave(2, 2, 10);
    wave(1, 1, 12);
    wave(4, 4, 8);
    wave(8, 8, 8);
    wave(4, 5, 1);
    wave(4, 4, 8);
    hold_low(300);
    wave(2, 2, 8);
    wave(3, 3, 8);
    wave(1, 255, 3);
    wave(1, 256, 2);
    wave(2, 2, 8);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    wave(2, 2, 8);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    wave(2, 2, 8);

    for (int it = 0; it < 80; it++) begin
      sel = $urandom_range(0, 9);
      d   = divs[$urandom_range(0, 7)];
      hi  = (d / 2 < 1) ? 1 : d / 2;
      if (sel <= 5) begin
        wave(hi, d - hi, $urandom_range(3, 10));
      end else if (sel == 6) begin
        wave(hi, d - hi + $urandom_range(1, 3), 1);
      end else if (sel == 7) begin
        hold_low($urandom_range(250, 300));
      end else if (sel == 8) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, cur_sig);
      end else if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(1, 2);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, cur_sig);
      end else begin
        wave(1, $urandom_range(253, 256), 3);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
